math_multiplier_cs_merge: RTL and testbench

//  Vector-merging stage that sits directly downstream of the carry-save multiplier array.
//  - Consumes the array's final-row sum and carry vectors, plus the already-resolved low product half.
//  - Adds the two vectors in a CHUNK-bit-per-stage pipelined carry-propagate adder.
//  - Emits the full 2*WIDTH-bit unsigned product under a valid/ready handshake.

---
 rtl/math_multiplier_cs_merge_pkg.sv | 32 +++
 rtl/math_multiplier_cpa_stage.sv | 29 ++
 rtl/math_multiplier_cs_merge.sv | 109 ++++++++++
 tb/tb_math_multiplier_cs_merge.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/math_multiplier_cs_merge_pkg.sv
// Shared constants and elaboration-time helpers for the carry-save merge stage.
package math_multiplier_cs_merge_pkg;

    // Default operand width and per-stage adder slice used by the array and the merge stage.
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CHUNK = 4;

    // Number of pipelined adder slices needed to cover 'width' bits, CHUNK at a time.
    function automatic int stages_for(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Width of slice k; only the top slice can be narrower than 'chunk'.
    function automatic int chunk_width(input int width, input int chunk, input int k);
        int rem;
        rem = width - k * chunk;
        return (rem < chunk) ? rem : chunk;
    endfunction

    // Bit mask covering the result bits produced by slice k.
    function automatic logic [63:0] chunk_mask(input int width, input int chunk, input int k);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 64; b++) begin
            if (b >= k * chunk && b < (k + 1) * chunk && b < width) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/math_multiplier_cpa_stage.sv
// One registered slice of the pipelined carry-propagate adder.
module math_multiplier_cpa_stage #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         en,
    input  logic         valid_in,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         valid_out
);

    // Add the slice with the incoming carry; hold everything while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            valid_out <= 1'b0;
        end else if (en) begin
            {cout, sum} <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            valid_out   <= valid_in;
        end
    end

endmodule

// File: rtl/math_multiplier_cs_merge.sv
// Merges the multiplier array's carry-save sum/carry rows into the final product
// through a CHUNK-bit-per-stage pipelined adder with a valid/ready output.
module math_multiplier_cs_merge
    import math_multiplier_cs_merge_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   s_in,
    input  logic [WIDTH-1:0]   c_in,
    input  logic [WIDTH-1:0]   lo_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] p_out,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int STAGES = stages_for(WIDTH, CHUNK);

    // Global advance: the whole pipeline moves unless a completed beat is waiting.
    logic adv;

    // Values presented to each stage (stage 0 from the ports, later stages from the previous skew regs).
    logic [WIDTH-1:0] st_s   [STAGES];
    logic [WIDTH-1:0] st_c   [STAGES];
    logic [WIDTH-1:0] st_lo  [STAGES];
    logic [WIDTH-1:0] st_acc [STAGES];
    logic             st_cin [STAGES];
    logic             st_vin [STAGES];

    // Skew registers carrying the untouched operands, lo half and partial result alongside each slice.
    logic [WIDTH-1:0] s_q      [STAGES];
    logic [WIDTH-1:0] c_q      [STAGES];
    logic [WIDTH-1:0] lo_q     [STAGES];
    logic [WIDTH-1:0] acc_q    [STAGES];
    logic [WIDTH-1:0] acc_done [STAGES];
    logic             cout_q   [STAGES];
    logic             valid_q  [STAGES];

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
            localparam int LSB = gi * CHUNK;
            localparam int CW  = chunk_width(WIDTH, CHUNK, gi);
            localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'(chunk_mask(WIDTH, CHUNK, gi));

            logic [CW-1:0] sum_q;

            if (gi == 0) begin : gen_head
                assign st_s[gi]   = s_in;
                assign st_c[gi]   = c_in;
                assign st_lo[gi]  = lo_in;
                assign st_acc[gi] = '0;
                assign st_cin[gi] = 1'b0;
                assign st_vin[gi] = in_valid;
            end else begin : gen_link
                assign st_s[gi]   = s_q[gi-1];
                assign st_c[gi]   = c_q[gi-1];
                assign st_lo[gi]  = lo_q[gi-1];
                assign st_acc[gi] = acc_done[gi-1];
                assign st_cin[gi] = cout_q[gi-1];
                assign st_vin[gi] = valid_q[gi-1];
            end

            math_multiplier_cpa_stage #(
                .W(CW)
            ) u_cpa (
                .clk       (clk),
                .rst_n     (rst_n),
                .a         (st_s[gi][LSB +: CW]),
                .b         (st_c[gi][LSB +: CW]),
                .cin       (st_cin[gi]),
                .en        (adv),
                .valid_in  (st_vin[gi]),
                .sum       (sum_q),
                .cout      (cout_q[gi]),
                .valid_out (valid_q[gi])
            );

            // Carry the rest of the beat alongside this slice so it stays aligned with its sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_q[gi]   <= '0;
                    c_q[gi]   <= '0;
                    lo_q[gi]  <= '0;
                    acc_q[gi] <= '0;
                end else if (adv) begin
                    s_q[gi]   <= st_s[gi];
                    c_q[gi]   <= st_c[gi];
                    lo_q[gi]  <= st_lo[gi];
                    acc_q[gi] <= st_acc[gi];
                end
            end

            // Splice this slice's sum into the partial upper result.
            assign acc_done[gi] = (acc_q[gi] & ~SLICE_MASK) | (WIDTH'(sum_q) << LSB);
        end
    endgenerate

    // Top slice carry-out is dropped: valid array rows never overflow WIDTH bits.
    assign p_out     = {acc_done[STAGES-1], lo_q[STAGES-1]};
    assign out_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_math_multiplier_cs_merge.sv
// Scoreboard bench for the carry-save merge stage (8/4 and ragged 6/4 instances).
module tb_math_multiplier_cs_merge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 8-bit instance
    logic [7:0]  s8, c8, lo8;
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [15:0] p8;

    // 6-bit instance (ragged top slice)
    logic [5:0]  s6, c6, lo6;
    logic        in_valid6, in_ready6, out_valid6, out_ready6;
    logic [11:0] p6;

    int checks = 0;
    int errors = 0;

    logic [15:0] q8[$];
    logic [11:0] q6[$];
    bit          rand_mode = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_p = '0;

    always #5 clk = ~clk;

    math_multiplier_cs_merge #(.WIDTH(8), .CHUNK(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .s_in(s8), .c_in(c8), .lo_in(lo8),
        .in_valid(in_valid8), .in_ready(in_ready8), .p_out(p8),
        .out_valid(out_valid8), .out_ready(out_ready8)
    );

    math_multiplier_cs_merge #(.WIDTH(6), .CHUNK(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .s_in(s6), .c_in(c6), .lo_in(lo6),
        .in_valid(in_valid6), .in_ready(in_ready6), .p_out(p6),
        .out_valid(out_valid6), .out_ready(out_ready6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: upper half is (s+c) modulo 2^W, lower half is lo unchanged.
    function automatic logic [15:0] model8(input int s, input int c, input int lo);
        return 16'(((s + c) % 256) * 256 + lo);
    endfunction

    function automatic logic [11:0] model6(input int s, input int c, input int lo);
        return 12'(((s + c) % 64) * 64 + lo);
    endfunction

    task automatic send8(input logic [7:0] s, input logic [7:0] c, input logic [7:0] lo);
        int n = 0;
        @(negedge clk);
        s8 = s; c8 = c; lo8 = lo; in_valid8 = 1'b1;
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready8) begin
            checks++; errors++;
            $display("FAIL send8_timeout in_ready actual=0 required=1");
        end else begin
            q8.push_back(model8(s, c, lo));
            $display("IN8  s=%02h c=%02h lo=%02h", s, c, lo);
        end
    endtask

    task automatic idle8();
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    task automatic send6(input logic [5:0] s, input logic [5:0] c, input logic [5:0] lo);
        @(negedge clk);
        s6 = s; c6 = c; lo6 = lo; in_valid6 = 1'b1;
        check("in_ready6", {31'd0, in_ready6}, 32'd1);
        q6.push_back(model6(s, c, lo));
        $display("IN6  s=%02h c=%02h lo=%02h", s, c, lo);
    endtask

    task automatic drain8(input string name);
        int n = 0;
        while (q8.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, q8.size(), 32'd0);
    endtask

    // Random backpressure, changed just after the active edge.
    always begin
        @(posedge clk);
        #2;
        if (rand_mode) out_ready8 = 1'($urandom_range(0, 1));
    end

    // Monitor for the 8-bit instance: handshake rules, stall freeze and scoreboard pop.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            check("in_ready_rule", {31'd0, in_ready8}, {31'd0, (~out_valid8 | out_ready8)});
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid8}, 32'd1);
                check("stall_p_out", {16'd0, p8}, {16'd0, prev_p});
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out8 actual=%04h required=none", p8);
                end else begin
                    logic [15:0] e;
                    e = q8.pop_front();
                    $display("OUT8 p=%04h exp=%04h", p8, e);
                    check("p_out8", {16'd0, p8}, {16'd0, e});
                end
            end
            prev_stall = out_valid8 && !out_ready8;
            prev_p     = p8;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Monitor for the 6-bit instance (consumer always ready).
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid6 && out_ready6) begin
            if (q6.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out6 actual=%03h required=none", p6);
            end else begin
                logic [11:0] e;
                e = q6.pop_front();
                $display("OUT6 p=%03h exp=%03h", p6, e);
                check("p_out6", {20'd0, p6}, {20'd0, e});
            end
        end
    end

    initial begin
        s8 = '0; c8 = '0; lo8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        s6 = '0; c6 = '0; lo6 = '0; in_valid6 = 1'b0; out_ready6 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
        check("rst_p_out", {16'd0, p8}, 32'd0);
        check("rst_p_out6", {20'd0, p6}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready8}, 32'd1);

        // Single beat with latency of two cycles
        send8(8'h7F, 8'h7F, 8'h01);
        idle8();
        #1 check("lat_cycle1_valid", {31'd0, out_valid8}, 32'd0);
        @(negedge clk);
        #1 check("lat_cycle2_valid", {31'd0, out_valid8}, 32'd1);
        check("single_p_out", {16'd0, p8}, 32'h0000_FE01);
        repeat (3) @(negedge clk);

        // Cross-chunk carry and discarded top carry
        send8(8'h0F, 8'h01, 8'h00);
        send8(8'hFF, 8'h01, 8'h00);
        idle8();
        drain8("drain_carry");

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            send8(8'(i), 8'(i), 8'(i));
            check("stream_in_ready", {31'd0, in_ready8}, 32'd1);
        end
        idle8();
        drain8("drain_stream");

        // Backpressure: three beats, consumer stalled for several cycles
        @(negedge clk);
        out_ready8 = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) send8(8'($urandom), 8'($urandom), 8'($urandom));
                idle8();
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check("bp_in_ready", {31'd0, in_ready8}, 32'd0);
                check("bp_out_valid", {31'd0, out_valid8}, 32'd1);
                out_ready8 = 1'b1;
            end
        join
        drain8("drain_backpressure");

        // Random traffic with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle8();
            else send8(8'($urandom), 8'($urandom), 8'($urandom));
        end
        idle8();
        drain8("drain_random");
        rand_mode = 1'b0;
        @(posedge clk); #2;
        out_ready8 = 1'b1;
        repeat (2) @(negedge clk);

        // Reset with two beats in flight
        send8(8'h12, 8'h34, 8'h56);
        send8(8'h21, 8'h43, 8'h65);
        idle8();
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid8}, 32'd0);
        check("midrst_p_out", {16'd0, p8}, 32'd0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 check("post_rst_quiet", {31'd0, out_valid8}, 32'd0);
        end

        // Ragged width instance
        send6(6'h3F, 6'h01, 6'h15);
        send6(6'h1F, 6'h01, 6'h2A);
        for (int i = 0; i < 6; i++) send6(6'($urandom), 6'($urandom), 6'($urandom));
        @(negedge clk);
        in_valid6 = 1'b0;
        begin
            int n = 0;
            while (q6.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (3) @(negedge clk);
        check("drain6_empty", q6.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
